// File: rtl/mips31_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips31_ctrl_pkg
//  Purpose  : Shared encodings for the MIPS31 multi-cycle controller.
//  Revision : 1.0  initial release
// ============================================================================
package mips31_ctrl_pkg;

    // FSM state encoding, visible on the debug state port
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_MEM    = 3'd4;
    localparam logic [2:0] c_ST_WB     = 3'd5;
    localparam logic [2:0] c_ST_ERR    = 3'd6;

    // instr_type bit indices; 0..15 are R-type ALU ops
    localparam logic [4:0] c_I_ADD   = 5'd0;
    localparam logic [4:0] c_I_JR    = 5'd16;
    localparam logic [4:0] c_I_ADDI  = 5'd17;
    localparam logic [4:0] c_I_LUI   = 5'd22;
    localparam logic [4:0] c_I_LW    = 5'd23;
    localparam logic [4:0] c_I_SW    = 5'd24;
    localparam logic [4:0] c_I_BEQ   = 5'd25;
    localparam logic [4:0] c_I_BNE   = 5'd26;
    localparam logic [4:0] c_I_SLTI  = 5'd27;
    localparam logic [4:0] c_I_SLTIU = 5'd28;
    localparam logic [4:0] c_I_J     = 5'd29;
    localparam logic [4:0] c_I_JAL   = 5'd30;

    localparam logic [1:0] c_PC_PLUS4  = 2'd0;
    localparam logic [1:0] c_PC_BRANCH = 2'd1;
    localparam logic [1:0] c_PC_JUMP   = 2'd2;
    localparam logic [1:0] c_PC_RS     = 2'd3;

    localparam logic [1:0] c_DST_RD = 2'd0;
    localparam logic [1:0] c_DST_RT = 2'd1;
    localparam logic [1:0] c_DST_RA = 2'd2;

    localparam logic [1:0] c_WB_ALU = 2'd0;
    localparam logic [1:0] c_WB_MEM = 2'd1;
    localparam logic [1:0] c_WB_PC4 = 2'd2;

    localparam logic [1:0] c_ERR_NONE    = 2'd0;
    localparam logic [1:0] c_ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] c_ERR_IMEM_TO = 2'd2;
    localparam logic [1:0] c_ERR_DMEM_TO = 2'd3;

    // Exactly one bit set, and that bit is a defined opcode (bit 31 is unused)
    function automatic logic is_legal(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0) && !v[31];
    endfunction

    function automatic logic [4:0] onehot_index(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 31; i++) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_controller_if
//  Purpose  : Instruction- and data-memory request/ack handshake bundle.
//  Revision : 1.0  initial release
// ============================================================================
interface multicycle_controller_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ack,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ack,
        output dmem_ack
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_timeout.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_timeout
//  Purpose  : Wait-cycle counter; expired fires on the limit-th unacked cycle.
//  Revision : 1.0  initial release
// ============================================================================
module ctrl_timeout #(
    parameter int MEM_TIMEOUT = 15
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  clr,
    input  wire  inc,
    output logic expired
);

    generate
        if (MEM_TIMEOUT > 0) begin : g_enabled
            localparam int              c_CW   = $clog2(MEM_TIMEOUT + 1);
            localparam logic [c_CW-1:0] c_LAST = c_CW'(MEM_TIMEOUT - 1);

            logic [c_CW-1:0] r_count;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_count <= '0;
                end else if (clr) begin
                    r_count <= '0;
                end else if (inc) begin
                    r_count <= r_count + c_CW'(1);
                end
            end

            // An ack in the limit cycle keeps inc low, so it wins over expiry
            assign expired = inc && (r_count == c_LAST);
        end else begin : g_disabled
            assign expired = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_controller
//  Purpose  : MIPS31 multi-cycle sequencer: fetch/decode/exec/mem/wb control.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_controller
    import mips31_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  wire                       clk,
    input  wire                       rst,
    input  wire                       en,
    input  wire        [31:0]         instr_type,
    input  wire                       zero,
    multicycle_controller_if.master   mem,
    output logic                      ir_we,
    output logic                      pc_we,
    output logic       [1:0]          pc_src,
    output logic       [4:0]          alu_op,
    output logic                      reg_we,
    output logic       [1:0]          reg_dst,
    output logic       [1:0]          wb_sel,
    output logic       [2:0]          state,
    output logic                      err,
    output logic       [1:0]          err_code,
    output logic       [CNT_W-1:0]    retired
);

    logic [2:0]       r_state;
    logic [4:0]       r_alu_op;
    logic             r_err;
    logic [1:0]       r_err_code;
    logic [CNT_W-1:0] r_retired;

    logic [2:0]       w_next_state;
    logic [1:0]       w_err_cause;
    logic             w_legal;
    logic             w_is_flow;
    logic             w_is_lw;
    logic             w_is_sw;
    logic             w_tmo_clr;
    logic             w_tmo_inc;
    logic             w_tmo_expired;
    logic             w_retire;

    assign w_legal   = is_legal(instr_type);
    assign w_is_lw   = (r_alu_op == c_I_LW);
    assign w_is_sw   = (r_alu_op == c_I_SW);
    assign w_is_flow = (r_alu_op == c_I_JR)  || (r_alu_op == c_I_BEQ) ||
                       (r_alu_op == c_I_BNE) || (r_alu_op == c_I_J)   ||
                       (r_alu_op == c_I_JAL);

    always_comb begin
        w_next_state = r_state;
        w_err_cause  = c_ERR_DMEM_TO;
        case (r_state)
            c_ST_IDLE: begin
                if (en) w_next_state = c_ST_FETCH;
            end
            c_ST_FETCH: begin
                w_err_cause = c_ERR_IMEM_TO;
                if (mem.imem_ack)       w_next_state = c_ST_DECODE;
                else if (w_tmo_expired) w_next_state = c_ST_ERR;
            end
            c_ST_DECODE: begin
                w_err_cause  = c_ERR_ILLEGAL;
                w_next_state = w_legal ? c_ST_EXEC : c_ST_ERR;
            end
            c_ST_EXEC: begin
                if (w_is_flow)               w_next_state = c_ST_FETCH;
                else if (w_is_lw || w_is_sw) w_next_state = c_ST_MEM;
                else                         w_next_state = c_ST_WB;
            end
            c_ST_MEM: begin
                if (mem.dmem_ack)       w_next_state = w_is_sw ? c_ST_FETCH : c_ST_WB;
                else if (w_tmo_expired) w_next_state = c_ST_ERR;
            end
            c_ST_WB:  w_next_state = c_ST_FETCH;
            c_ST_ERR: w_next_state = c_ST_ERR;
            default:  w_next_state = c_ST_IDLE;
        endcase
    end

    // The wait counter restarts on every fresh entry into a request state
    assign w_tmo_clr = (w_next_state != r_state) &&
                       ((w_next_state == c_ST_FETCH) || (w_next_state == c_ST_MEM));
    assign w_tmo_inc = ((r_state == c_ST_FETCH) && !mem.imem_ack) ||
                       ((r_state == c_ST_MEM)   && !mem.dmem_ack);
    assign w_retire  = (w_next_state == c_ST_FETCH) &&
                       ((r_state == c_ST_EXEC) || (r_state == c_ST_MEM) || (r_state == c_ST_WB));

    ctrl_timeout #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_tmo_clr),
        .inc     (w_tmo_inc),
        .expired (w_tmo_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_alu_op   <= '0;
            r_err      <= 1'b0;
            r_err_code <= c_ERR_NONE;
            r_retired  <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == c_ST_DECODE) && w_legal) begin
                r_alu_op <= onehot_index(instr_type);
            end
            if ((w_next_state == c_ST_ERR) && (r_state != c_ST_ERR)) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_cause;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = c_PC_PLUS4;
        alu_op       = 5'd0;
        reg_we       = 1'b0;
        reg_dst      = c_DST_RD;
        wb_sel       = c_WB_ALU;
        case (r_state)
            c_ST_FETCH: begin
                mem.imem_req = 1'b1;
                if (mem.imem_ack) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                end
            end
            c_ST_EXEC: begin
                alu_op = r_alu_op;
                case (r_alu_op)
                    c_I_BEQ: begin
                        pc_we  = zero;
                        pc_src = c_PC_BRANCH;
                    end
                    c_I_BNE: begin
                        pc_we  = ~zero;
                        pc_src = c_PC_BRANCH;
                    end
                    c_I_J: begin
                        pc_we  = 1'b1;
                        pc_src = c_PC_JUMP;
                    end
                    c_I_JAL: begin
                        pc_we   = 1'b1;
                        pc_src  = c_PC_JUMP;
                        reg_we  = 1'b1;
                        reg_dst = c_DST_RA;
                        wb_sel  = c_WB_PC4;
                    end
                    c_I_JR: begin
                        pc_we  = 1'b1;
                        pc_src = c_PC_RS;
                    end
                    default: ;
                endcase
            end
            c_ST_MEM: begin
                alu_op       = r_alu_op;
                mem.dmem_req = 1'b1;
                mem.dmem_we  = w_is_sw;
            end
            c_ST_WB: begin
                alu_op  = r_alu_op;
                reg_we  = 1'b1;
                reg_dst = (r_alu_op < c_I_JR) ? c_DST_RD : c_DST_RT;
                wb_sel  = w_is_lw ? c_WB_MEM : c_WB_ALU;
            end
            default: ;
        endcase
    end

    assign state    = r_state;
    assign err      = r_err;
    assign err_code = r_err_code;
    assign retired  = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_controller
//  Purpose  : Directed + random instruction streams against a cycle-count model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_controller;

    localparam int c_T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] instr_type = 32'd0;
    logic        ir_we, pc_we, reg_we, err;
    logic [1:0]  pc_src, reg_dst, wb_sel, err_code;
    logic [4:0]  alu_op;
    logic [2:0]  state;
    logic [31:0] retired;

    int total = 0;
    int bad   = 0;
    int exp_retired = 0;

    multicycle_controller_if mem_if();

    multicycle_controller #(
        .MEM_TIMEOUT (c_T),
        .CNT_W       (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .instr_type (instr_type),
        .zero       (zero),
        .mem        (mem_if),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .alu_op     (alu_op),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .wb_sel     (wb_sel),
        .state      (state),
        .err        (err),
        .err_code   (err_code),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] strobes();
        return {15'd0, mem_if.imem_req, mem_if.dmem_req, mem_if.dmem_we, ir_we, pc_we,
                reg_we, pc_src, reg_dst, wb_sel, alu_op};
    endfunction

    // Reset, confirm the idle picture, then start execution (leaves state in FETCH)
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        mem_if.imem_ack = 1'b0;
        mem_if.dmem_ack = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_err", {err_code, err}, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_strobes", strobes(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_retired = 0;
        @(negedge clk);
        check("idle_hold", 32'(state), 32'd0);
        en = 1'b1;
        @(posedge clk);
        #1;
        check("idle_to_fetch", 32'(state), 32'd1);
        en = 1'b0;
    endtask

    // Executes one instruction; ia/da = wait cycles before imem/dmem ack
    task automatic run_instr(input logic [31:0] word, input logic z, input int ia, input int da);
        int  cyc, n_imem, n_dmem, n_dwe, n_ir, n_pc, n_reg, ic, dc, idx;
        int  e_cyc, e_imem, e_dmem, e_dwe, e_ir, e_pc, e_reg, e_src, e_dst, e_wb, e_code;
        logic [1:0] o_src, o_dst, o_wb, o_fsrc;
        logic [4:0] o_alu;
        logic [2:0] cur, nxt;
        bit done, legal, flow, lw, sw;

        // ---- reference model: expected totals for this instruction ----
        legal = ($countones(word) == 1) && !word[31];
        idx = 0;
        for (int i = 0; i < 31; i++) if (word[i]) idx = i;
        lw   = legal && idx == 23;
        sw   = legal && idx == 24;
        flow = legal && (idx == 16 || idx == 25 || idx == 26 || idx == 29 || idx == 30);
        e_dmem = 0; e_dwe = 0; e_reg = 0; e_src = 0; e_dst = 0; e_wb = 0; e_code = 0;
        if (ia >= c_T) begin
            e_code = 2; e_cyc = c_T; e_imem = c_T; e_ir = 0; e_pc = 0;
        end else begin
            e_imem = ia + 1; e_ir = 1; e_pc = 1; e_cyc = ia + 2;
            if (!legal) begin
                e_code = 1;
            end else begin
                e_cyc++;
                if (flow) begin
                    e_pc += (idx == 25) ? int'(z) : (idx == 26) ? int'(!z) : 1;
                    e_src = (idx == 25 || idx == 26) ? 1 : (idx == 16) ? 3 : 2;
                    if (idx == 30) begin e_reg = 1; e_dst = 2; e_wb = 2; end
                end else if (lw || sw) begin
                    if (da >= c_T) begin
                        e_code = 3; e_cyc += c_T; e_dmem = c_T; e_dwe = sw ? c_T : 0;
                    end else begin
                        e_cyc += da + 1; e_dmem = da + 1; e_dwe = sw ? da + 1 : 0;
                        if (lw) begin e_cyc++; e_reg = 1; e_dst = 1; e_wb = 1; end
                    end
                end else begin
                    e_cyc++; e_reg = 1; e_dst = (idx <= 15) ? 0 : 1;
                end
            end
        end
        if (e_code == 0) exp_retired++;

        // ---- drive and observe ----
        instr_type = word;
        zero = z;
        cyc = 0; n_imem = 0; n_dmem = 0; n_dwe = 0; n_ir = 0; n_pc = 0; n_reg = 0;
        ic = 0; dc = 0; done = 0; nxt = 3'd0;
        o_src = 0; o_dst = 0; o_wb = 0; o_alu = 0; o_fsrc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            en = 1'($urandom_range(0, 1));
            mem_if.imem_ack = mem_if.imem_req ? (ic == ia) : 1'($urandom_range(0, 1));
            mem_if.dmem_ack = mem_if.dmem_req ? (dc == da) : 1'($urandom_range(0, 1));
            #1;
            cur = state;
            cyc++;
            if (mem_if.imem_req) begin n_imem++; ic++; end
            if (mem_if.dmem_req) begin n_dmem++; dc++; if (mem_if.dmem_we) n_dwe++; end
            if (ir_we) begin n_ir++; o_fsrc = pc_src; end
            if (pc_we) n_pc++;
            if (reg_we) begin n_reg++; o_dst = reg_dst; o_wb = wb_sel; end
            if (cur == 3'd3) begin o_alu = alu_op; o_src = pc_src; end
            @(posedge clk);
            #1;
            nxt = state;
            done = (nxt == 3'd6) || (nxt == 3'd1 && cur != 3'd1);
        end
        mem_if.imem_ack = 1'b0;
        mem_if.dmem_ack = 1'b0;

        check("run_bound", 32'(done), 32'd1);
        check("cycles", cyc, e_cyc);
        check("imem_req_cycles", n_imem, e_imem);
        check("dmem_req_cycles", n_dmem, e_dmem);
        check("dmem_we_cycles", n_dwe, e_dwe);
        check("ir_we_count", n_ir, e_ir);
        check("pc_we_count", n_pc, e_pc);
        check("reg_we_count", n_reg, e_reg);
        if (e_ir == 1) check("fetch_pc_src", 32'(o_fsrc), 32'd0);
        if (flow && e_code == 0) check("exec_pc_src", 32'(o_src), e_src);
        if (e_reg == 1) begin
            check("reg_dst", 32'(o_dst), e_dst);
            check("wb_sel", 32'(o_wb), e_wb);
        end
        if (legal && e_code != 2) check("alu_op", 32'(o_alu), idx);
        check("end_state", 32'(nxt), (e_code != 0) ? 32'd6 : 32'd1);
        check("err_flags", {err_code, err}, (e_code != 0) ? ((e_code << 1) | 1) : 32'd0);
        check("retired", retired, exp_retired);

        if (e_code != 0 || nxt == 3'd6) begin
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                en = 1'b1;
                mem_if.imem_ack = 1'b1;
                mem_if.dmem_ack = 1'b1;
                #1;
                check("err_no_strobes", strobes(), 32'd0);
                check("err_sticky", {state, err}, {3'd6, 1'b1});
            end
            do_reset();
        end
    endtask

    initial begin
        mem_if.imem_ack = 1'b0;
        mem_if.dmem_ack = 1'b0;
        do_reset();

        run_instr(32'h1 << 0,  1'b0, 0, 0);   // ADD
        run_instr(32'h1 << 23, 1'b0, 0, 3);   // LW, dmem ack after 3 waits
        run_instr(32'h1 << 25, 1'b1, 0, 0);   // BEQ taken
        run_instr(32'h1 << 25, 1'b0, 0, 0);   // BEQ not taken
        run_instr(32'h1 << 26, 1'b1, 0, 0);   // BNE not taken
        run_instr(32'h1 << 26, 1'b0, 0, 0);   // BNE taken
        run_instr(32'h1 << 30, 1'b0, 1, 0);   // JAL
        run_instr(32'h1 << 29, 1'b0, 0, 0);   // J
        run_instr(32'h1 << 16, 1'b0, 2, 0);   // JR
        run_instr(32'h1 << 24, 1'b0, 0, 1);   // SW
        run_instr(32'h1 << 17, 1'b0, 0, 0);   // ADDI
        run_instr(32'h1 << 28, 1'b0, 3, 0);   // SLTIU, ack exactly at limit
        run_instr(32'h0000_0003, 1'b0, 0, 0); // two bits set
        run_instr(32'h0, 1'b0, 0, 0);         // no bit set
        run_instr(32'h1 << 0, 1'b0, 10, 0);   // imem never acks
        run_instr(32'h1 << 24, 1'b0, 0, 10);  // dmem never acks
        run_instr(32'h1 << 23, 1'b0, 0, 3);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] w;
            int ia, da;
            w  = 32'h1 << $urandom_range(0, 30);
            if ($urandom_range(0, 11) == 0) w = w | (32'h1 << $urandom_range(0, 31));
            ia = ($urandom_range(0, 9) == 0) ? c_T : $urandom_range(0, c_T - 1);
            da = ($urandom_range(0, 9) == 0) ? c_T : $urandom_range(0, c_T - 1);
            run_instr(w, 1'($urandom_range(0, 1)), ia, da);
        end

        // Make sure something has retired, then reset in the middle of a SW
        run_instr(32'h1 << 0, 1'b0, 0, 0);
        instr_type = 32'h1 << 24;
        @(negedge clk); mem_if.imem_ack = 1'b1;
        @(negedge clk); mem_if.imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("sw_in_mem", {state, mem_if.dmem_req, mem_if.dmem_we}, {3'd4, 1'b1, 1'b1});
        #2;
        rst = 1'b1;
        #1;
        check("rst_drops_req", {mem_if.dmem_req, mem_if.dmem_we, reg_we, pc_we}, 32'd0);
        check("rst_mid_state", 32'(state), 32'd0);
        check("rst_mid_retired", retired, 32'd0);
        do_reset();
        run_instr(32'h1 << 24, 1'b0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle sequencer for the MIPS31 datapath. It consumes the one-hot instruction_type word from the instruction decoder and the ALU zero flag.
- It drives the instruction-memory and data-memory request/ack handshakes, PC/IR/register-file write enables and the datapath mux selects.
- It detects illegal encodings and memory timeouts, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 15, max cycles a memory req may wait for ack before error; 0 disables the timeout.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  start/continue execution; sampled only in IDLE.
- instr_type  in  32  one-hot decoder output. Bit n: 0 ADD … 16 JR, 17 ADDI … 28 SLTIU, 29 J, 30 JAL.
- zero  in  1  ALU result==0, valid in EXEC.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  instruction memory ack; data valid this cycle.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1=store; valid while dmem_req.
- dmem_ack  in  1  data memory ack.
- ir_we  out  1  load instruction register.
- pc_we  out  1  update PC.
- pc_src  out  2  0=PC+4, 1=branch target, 2=jump target, 3=rs (JR).
- alu_op  out  5  index of the active instr_type bit (0..30).
- reg_we  out  1  register-file write.
- reg_dst  out  2  0=rd, 1=rt, 2=$31.
- wb_sel  out  2  0=ALU, 1=memory data, 2=PC+4.
- state  out  3  current state, debug.
- err  out  1  sticky error flag.
- err_code  out  2  0=none, 1=illegal, 2=imem timeout, 3=dmem timeout.
- retired  out  CNT_W  retired instruction count.

Behaviour:
- Reset (async, rst=1): state=IDLE; err=0; err_code=0; retired=0; timeout counter=0. All outputs derive from state, so every strobe is 0 and pc_src/reg_dst/wb_sel/alu_op=0.
- Outputs are Moore/Mealy combinational on the registered state plus inputs. State, err, err_code and retired are registered.
- IDLE: no strobes. en=1 → FETCH.
- FETCH: imem_req=1, held until ack. On the imem_ack cycle: ir_we=1, pc_we=1, pc_src=0, → DECODE.
- DECODE: 1 cycle, no strobes.
  - instr_type==0 or more than one bit set → ERR, err_code=1.
  - Otherwise latch alu_op = bit index → EXEC.
- EXEC: 1 cycle; instruction completes here unless noted.
  - BEQ: pc_we=zero, pc_src=1 → FETCH.
  - BNE: pc_we=~zero, pc_src=1 → FETCH.
  - J: pc_we=1, pc_src=2 → FETCH.
  - JAL: pc_we=1, pc_src=2, reg_we=1, reg_dst=2, wb_sel=2 → FETCH.
  - JR: pc_we=1, pc_src=3 → FETCH.
  - LW/SW → MEM.
  - All others → WB.
- MEM: dmem_req=1, dmem_we=SW; req and we held stable until dmem_ack.
  - On ack, SW → FETCH.
  - On ack, LW → WB.
- WB: reg_we=1 for 1 cycle.
  - R-type: reg_dst=0, wb_sel=0.
  - I-type ALU ops (ADDI..LUI, SLTI, SLTIU): reg_dst=1, wb_sel=0.
  - LW: reg_dst=1, wb_sel=1.
  - Then → FETCH.
- Retirement: retired += 1 (wraps modulo 2^CNT_W) on every transition into FETCH from EXEC, MEM or WB. ERR transitions never increment it.
- Cycle counts with zero-wait memory (ack in the first req cycle):
  - Branch/jump: 3 cycles.
  - SW: 4 cycles.
  - ALU op: 4 cycles.
  - LW: 5 cycles.
- Timeout (MEM_TIMEOUT>0): counter clears on entering FETCH/MEM and increments each req cycle without ack. When the counter reaches MEM_TIMEOUT with no ack in that cycle → ERR, err_code=2 (FETCH) or 3 (MEM).
  - An ack in the same cycle the count hits the limit wins; no error.
- ERR: all strobes 0, err=1. Terminal until rst.
- Ack arriving with no request is ignored. en is ignored outside IDLE.
- rst mid-transaction drops req the same cycle (asynchronous); no write strobe is asserted after rst rises.

Decomposition:
- Package mips31_ctrl_pkg holds:
  - the state encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6;
  - instr_type bit-index constants;
  - pc_src, reg_dst, wb_sel and err_code encodings.
- One sub-module, ctrl_timeout: a clear/increment counter with an expired flag, parameterised by MEM_TIMEOUT.

Test Plan:
- Reset then en=1; ADD type (bit0), imem/dmem ack immediate → states 1,2,3,5,1; reg_we=1 with reg_dst=0 in WB; retired=1.
- LW (bit23) with dmem_ack delayed 3 cycles → dmem_req high 4 cycles, dmem_we=0; then WB with wb_sel=1, reg_dst=1; retired increments once.
- BEQ with zero=1 → pc_we=1, pc_src=1 in EXEC. BEQ with zero=0 → pc_we=0. BNE inverse. Each retires in 3 cycles.
- instr_type=0x00000003 (two bits set) → ERR, err=1, err_code=1; no strobes until rst.
- MEM_TIMEOUT=4, imem_ack never asserted → ERR with err_code=2 after 4 req cycles. Repeat with ack on cycle 4 → no error.
- JAL → reg_we=1, reg_dst=2, wb_sel=2, pc_src=2 in one EXEC cycle. Assert rst mid-MEM on a SW → dmem_req drops immediately, state=IDLE, retired=0.
